// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and constants for the logic-BIST sequencer
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        CMP     = 2'd3
    } bist_state_t;

    localparam int PAT_CNT_W = 16;

    // x^60+x^59+1 and x^26+x^6+x^2+x+1, as masks of the register bits XORed into feedback
    localparam logic [59:0] LFSR_TAPS = 60'hC00_0000_0000_0000;
    localparam logic [25:0] MISR_TAPS = 26'h200_0023;

endpackage

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - generic multiple-input signature register with clear and enable
module bist_misr
    import bist_pkg::*;
#(
    parameter int           W    = 26,
    parameter logic [W-1:0] TAPS = W'(MISR_TAPS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_sig
);

    logic [W-1:0] r_sig;
    logic         w_fb;

    assign w_fb  = ^(r_sig & TAPS);
    assign o_sig = r_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (i_clear) begin
            r_sig <= '0;
        end else if (i_enable) begin
            r_sig <= {r_sig[W-2:0], w_fb} ^ i_data;
        end
    end

endmodule

// File: rtl/bist_seq_ctrl.sv
// rtl/bist_seq_ctrl.sv - LFSR/MISR logic-BIST sequencer; BIST_OBS_EN adds a capture observation port
module bist_seq_ctrl
    import bist_pkg::*;
#(
    parameter int              IN_W          = 60,
    parameter int              OUT_W         = 26,
    parameter int              NUM_PATTERNS  = 1024,
    parameter int              SETTLE_CYCLES = 2,
    parameter logic [IN_W-1:0] LFSR_SEED     = {{(IN_W-1){1'b0}}, 1'b1}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [OUT_W-1:0]     sig_expected,
    input  logic [OUT_W-1:0]     cut_out,
`ifdef BIST_OBS_EN
    input  logic                 obs_ready,
    output logic                 obs_valid,
    output logic [OUT_W-1:0]     obs_data,
`endif
    output logic [IN_W-1:0]      cut_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [OUT_W-1:0]     signature,
    output logic [PAT_CNT_W-1:0] pat_cnt
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    bist_state_t          r_state;
    bist_state_t          w_next;
    logic [IN_W-1:0]      r_lfsr;
    logic [PAT_CNT_W-1:0] r_pat_cnt;
    logic [SET_W-1:0]     r_settle_cnt;
    logic                 r_pass;
    logic                 w_done;
    logic                 w_start_ok;
    logic                 w_cap_fire;
    logic                 w_last;
    logic                 w_settle_end;
    logic [OUT_W-1:0]     w_misr;

`ifdef BIST_OBS_EN
    assign w_cap_fire = (r_state == CAPTURE) && obs_ready && !abort;
    assign obs_valid  = (r_state == CAPTURE);
    assign obs_data   = cut_out;
`else
    assign w_cap_fire = (r_state == CAPTURE) && !abort;
`endif

    assign w_start_ok   = (r_state == IDLE) && start && !abort;
    assign w_last       = (r_pat_cnt == PAT_CNT_W'(NUM_PATTERNS - 1));
    assign w_settle_end = (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_next = SETTLE;
                SETTLE:  if (w_settle_end) w_next = CAPTURE;
                CAPTURE: if (w_cap_fire) w_next = w_last ? CMP : SETTLE;
                CMP: begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // abort freezes the captured data but always clears pass once a run was underway
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr       <= '0;
            r_pat_cnt    <= '0;
            r_settle_cnt <= '0;
            r_pass       <= 1'b0;
        end else if (abort) begin
            r_settle_cnt <= '0;
            if (r_state != IDLE) r_pass <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_lfsr       <= LFSR_SEED;
                        r_pat_cnt    <= '0;
                        r_settle_cnt <= '0;
                        r_pass       <= 1'b0;
                    end
                end
                SETTLE: begin
                    r_settle_cnt <= w_settle_end ? '0 : r_settle_cnt + 1'b1;
                end
                CAPTURE: begin
                    if (w_cap_fire) begin
                        r_lfsr    <= {r_lfsr[IN_W-2:0], ^(r_lfsr & IN_W'(LFSR_TAPS))};
                        r_pat_cnt <= r_pat_cnt + 1'b1;
                    end
                end
                CMP: begin
                    r_pass <= (w_misr == sig_expected);
                end
                default: ;
            endcase
        end
    end

    bist_misr #(
        .W    (OUT_W),
        .TAPS (OUT_W'(MISR_TAPS))
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_start_ok),
        .i_enable (w_cap_fire),
        .i_data   (cut_out),
        .o_sig    (w_misr)
    );

    assign cut_in    = r_lfsr;
    assign busy      = (r_state != IDLE);
    assign done      = w_done;
    assign pass      = r_pass;
    assign signature = w_misr;
    assign pat_cnt   = r_pat_cnt;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// tb/tb_bist_seq_ctrl.sv - self-checking bench for bist_seq_ctrl (two parameterisations, optional BIST_OBS_EN)
module tb_bist_seq_ctrl;

    localparam int NP1 = 4;
    localparam int ST1 = 1;
    localparam int NP2 = 1;
    localparam int ST2 = 3;
    localparam logic [59:0] SEED = 60'h1;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [25:0] sig_exp, sig_exp2, cut_out1, cut_out2, sig1, sig2;
    logic [59:0] cut_in1, cut_in2;
    logic        busy1, done1, pass1, busy2, done2, pass2;
    logic [15:0] pat1, pat2;
    logic [1:0]  mode;
    logic [25:0] key;
    int          errors = 0;
    int          checks = 0;
    int          dc1, nd1, dc2, nd2;
    int          obs_rel = 0;
    logic        busy_tr [0:31];
    logic        ov_tr   [0:31];
    logic [25:0] sig_tr  [0:31];
    logic [59:0] cin_tr  [0:31];
    logic [15:0] pat_tr  [0:31];

    always #5 clk = ~clk;

    function automatic logic [25:0] cut_f(input logic [59:0] x, input logic [1:0] md, input logic [25:0] k);
        case (md)
            2'd0:    return 26'h0;
            2'd1:    return x[25:0];
            default: return x[25:0] ^ x[59:34] ^ k;
        endcase
    endfunction

    always_comb cut_out1 = cut_f(cut_in1, mode, key);
    always_comb cut_out2 = cut_f(cut_in2, mode, key);

`ifdef BIST_OBS_EN
    logic        obs_ready, obs_valid1, obs_valid2;
    logic [25:0] obs_data1, obs_data2;
`endif

    bist_seq_ctrl #(.NUM_PATTERNS(NP1), .SETTLE_CYCLES(ST1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sig_expected(sig_exp), .cut_out(cut_out1),
`ifdef BIST_OBS_EN
        .obs_ready(obs_ready), .obs_valid(obs_valid1), .obs_data(obs_data1),
`endif
        .cut_in(cut_in1), .busy(busy1), .done(done1), .pass(pass1),
        .signature(sig1), .pat_cnt(pat1)
    );

    bist_seq_ctrl #(.NUM_PATTERNS(NP2), .SETTLE_CYCLES(ST2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sig_expected(sig_exp2), .cut_out(cut_out2),
`ifdef BIST_OBS_EN
        .obs_ready(obs_ready), .obs_valid(obs_valid2), .obs_data(obs_data2),
`endif
        .cut_in(cut_in2), .busy(busy2), .done(done2), .pass(pass2),
        .signature(sig2), .pat_cnt(pat2)
    );

    // Reference: walk the pattern sequence and fold each CUT response into the signature.
    task automatic model_run(input int np, output logic [25:0] m, output logic [59:0] l);
        logic fb;
        l = SEED;
        m = 26'h0;
        for (int k = 0; k < np; k++) begin
            fb = m[25] ^ m[5] ^ m[1] ^ m[0];
            m  = {m[24:0], fb} ^ cut_f(l, mode, key);
            l  = {l[58:0], l[59] ^ l[58]};
        end
    endtask

    // Pulses start in cycle 0, then records outputs at mid-cycle for cycles 1..limit.
    task automatic run_watch(input int limit, input int extra_start, input int abort_cyc);
        dc1 = -1; nd1 = 0; dc2 = -1; nd2 = 0;
        @(posedge clk); #1 start = 1'b1; abort = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk); #1;
            start = (c == extra_start);
            abort = (c == abort_cyc);
`ifdef BIST_OBS_EN
            obs_ready = (c >= obs_rel);
            ov_tr[c]  = 1'b0;
`endif
            @(negedge clk);
`ifdef BIST_OBS_EN
            ov_tr[c] = obs_valid1;
`endif
            busy_tr[c] = busy1;
            sig_tr[c]  = sig1;
            cin_tr[c]  = cut_in1;
            pat_tr[c]  = pat1;
            if (done1) begin nd1++; if (dc1 < 0) dc1 = c; end
            if (done2) begin nd2++; if (dc2 < 0) dc2 = c; end
        end
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sig_exp = '0; sig_exp2 = '0;
        mode = 2'd0; key = '0;
`ifdef BIST_OBS_EN
        obs_ready = 1'b1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cut_in1 !== 60'h0) begin errors++; $display("FAIL reset_cut_in: got %h want 0", cut_in1); end
        checks++; if (sig1 !== 26'h0) begin errors++; $display("FAIL reset_signature: got %h want 0", sig1); end
        checks++; if (pat1 !== 16'h0) begin errors++; $display("FAIL reset_pat_cnt: got %0d want 0", pat1); end
        checks++; if ({busy1, done1, pass1} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy1, done1, pass1}); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_zero_run();
        mode = 2'd0; sig_exp = 26'h0; sig_exp2 = 26'h0;
        run_watch(14, -1, -1);
        checks++; if (dc1 !== 9) begin errors++; $display("FAIL zero_done_cycle: got %0d want 9", dc1); end
        checks++; if (nd1 !== 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", nd1); end
        checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL zero_pass: got %b want 1", pass1); end
        checks++; if (pat1 !== 16'd4) begin errors++; $display("FAIL zero_pat_cnt: got %0d want 4", pat1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL zero_busy_after: got %b want 0", busy1); end
        checks++; if (dc2 !== NP2 * (ST2 + 1) + 1) begin errors++; $display("FAIL one_pat_done_cycle: got %0d want %0d", dc2, NP2 * (ST2 + 1) + 1); end
        checks++; if (pat2 !== 16'd1) begin errors++; $display("FAIL one_pat_cnt: got %0d want 1", pat2); end
    endtask

    task automatic test_fail_sig();
        mode = 2'd0; sig_exp = 26'h1;
        run_watch(14, -1, -1);
        checks++; if (dc1 !== 9) begin errors++; $display("FAIL failsig_done_cycle: got %0d want 9", dc1); end
        checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL failsig_pass: got %b want 0", pass1); end
        checks++; if (sig1 !== 26'h0) begin errors++; $display("FAIL failsig_signature: got %h want 0", sig1); end
    endtask

    task automatic test_first_capture();
        logic [25:0] em;
        logic [59:0] el;
        mode = 2'd1;
        model_run(NP1, em, el);
        sig_exp = em;
        run_watch(14, -1, -1);
        checks++; if (sig_tr[3] !== SEED[25:0]) begin errors++; $display("FAIL first_cap_signature: got %h want %h", sig_tr[3], SEED[25:0]); end
        checks++; if (cin_tr[3] !== 60'h2) begin errors++; $display("FAIL first_cap_cut_in: got %h want 2", cin_tr[3]); end
        checks++; if (pat_tr[3] !== 16'd1) begin errors++; $display("FAIL first_cap_pat_cnt: got %0d want 1", pat_tr[3]); end
        checks++; if (sig1 !== em || pass1 !== 1'b1) begin errors++; $display("FAIL ident_final: got %h/%b want %h/1", sig1, pass1, em); end
    endtask

    task automatic test_random_runs();
        logic [25:0] em, em2;
        logic [59:0] el, el2;
        logic        good;
        for (int r = 0; r < 6; r++) begin
            mode = 2'd2;
            key  = 26'($urandom);
            model_run(NP1, em, el);
            model_run(NP2, em2, el2);
            good     = (r % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            sig_exp  = good ? em : em ^ (26'h1 << $urandom_range(0, 25));
            sig_exp2 = em2;
            run_watch(14, -1, -1);
            checks++; if (dc1 !== 9 || nd1 !== 1) begin errors++; $display("FAIL rand_done[%0d]: got cyc %0d cnt %0d want 9/1", r, dc1, nd1); end
            checks++; if (sig1 !== em) begin errors++; $display("FAIL rand_signature[%0d]: got %h want %h", r, sig1, em); end
            checks++; if (pass1 !== good) begin errors++; $display("FAIL rand_pass[%0d]: got %b want %b", r, pass1, good); end
            checks++; if (cut_in1 !== el) begin errors++; $display("FAIL rand_cut_in[%0d]: got %h want %h", r, cut_in1, el); end
            checks++; if (sig2 !== em2 || pass2 !== 1'b1) begin errors++; $display("FAIL rand_one_pat[%0d]: got %h/%b want %h/1", r, sig2, pass2, em2); end
        end
    endtask

    task automatic test_abort();
        logic [25:0] em1, em4;
        logic [59:0] el;
        mode = 2'd2;
        key  = 26'($urandom);
        model_run(1, em1, el);
        model_run(NP1, em4, el);
        sig_exp = em4;
        run_watch(14, -1, 4);
        checks++; if (nd1 !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", nd1); end
        checks++; if (busy_tr[4] !== 1'b1 || busy_tr[5] !== 1'b0) begin errors++; $display("FAIL abort_idle_timing: got busy4=%b busy5=%b want 1/0", busy_tr[4], busy_tr[5]); end
        checks++; if (pat1 !== 16'd1 || sig1 !== em1) begin errors++; $display("FAIL abort_frozen: got pat %0d sig %h want 1/%h", pat1, sig1, em1); end
        checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL abort_pass: got %b want 0", pass1); end
        run_watch(14, -1, -1);
        checks++; if (dc1 !== 9 || sig1 !== em4 || pass1 !== 1'b1) begin errors++; $display("FAIL abort_rerun: got cyc %0d sig %h pass %b want 9/%h/1", dc1, sig1, pass1, em4); end
    endtask

    task automatic test_busy_start();
        logic [25:0] em;
        logic [59:0] el;
        mode = 2'd2;
        key  = 26'($urandom);
        model_run(NP1, em, el);
        sig_exp = em;
        run_watch(14, 5, -1);
        checks++; if (dc1 !== 9 || nd1 !== 1) begin errors++; $display("FAIL busy_start_done: got cyc %0d cnt %0d want 9/1", dc1, nd1); end
        checks++; if (sig1 !== em || pass1 !== 1'b1) begin errors++; $display("FAIL busy_start_sig: got %h/%b want %h/1", sig1, pass1, em); end
    endtask

    task automatic test_start_abort_idle();
        int seen_busy;
        seen_busy = 0;
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy1 || done1) seen_busy++;
        end
        checks++; if (seen_busy !== 0) begin errors++; $display("FAIL start_abort_idle: got %0d busy cycles want 0", seen_busy); end
    endtask

    task automatic test_reset_mid_run();
        mode = 2'd2;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (cut_in1 !== 60'h0 || pat1 !== 16'h0 || sig1 !== 26'h0) begin errors++; $display("FAIL midrun_reset_data: got %h/%0d/%h want 0/0/0", cut_in1, pat1, sig1); end
        checks++; if (busy1 !== 1'b0 || pass1 !== 1'b0) begin errors++; $display("FAIL midrun_reset_flags: got busy %b pass %b want 0/0", busy1, pass1); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

`ifdef BIST_OBS_EN
    task automatic test_obs_stall();
        logic [25:0] em;
        logic [59:0] el;
        mode = 2'd2;
        key  = 26'($urandom);
        model_run(NP1, em, el);
        sig_exp = em;
        obs_ready = 1'b0;
        obs_rel   = 5;
        run_watch(16, -1, -1);
        obs_rel   = 0;
        obs_ready = 1'b1;
        checks++; if (dc1 !== 12) begin errors++; $display("FAIL obs_done_cycle: got %0d want 12", dc1); end
        checks++; if (sig1 !== em || pass1 !== 1'b1) begin errors++; $display("FAIL obs_signature: got %h/%b want %h/1", sig1, pass1, em); end
        checks++; if (ov_tr[2] !== 1'b1 || ov_tr[4] !== 1'b1 || ov_tr[1] !== 1'b0) begin errors++; $display("FAIL obs_valid: got %b%b%b want 011", ov_tr[1], ov_tr[2], ov_tr[4]); end
        checks++; if (pat_tr[4] !== 16'd0 || cin_tr[4] !== SEED) begin errors++; $display("FAIL obs_frozen: got pat %0d cut_in %h want 0/%h", pat_tr[4], cin_tr[4], SEED); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_run();
        test_fail_sig();
        test_first_capture();
        test_random_runs();
        test_abort();
        test_busy_start();
        test_start_abort_idle();
        test_reset_mid_run();
`ifdef BIST_OBS_EN
        test_obs_stall();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
